reverse_job_frontend: RTL and testbench
=======================================

// Module: reverse_job_frontend
// PURPOSE
//  Job sequencer in front of the digit-reverse controller/datapath pair.
//  - Accepts operands on a valid/ready input and presents each one to the datapath.
//  - Drives the controller's start/Done protocol and captures the reversed result.
//  - Presents the result on a valid/ready output, together with the job's cycle count.
//  - Decouples upstream and downstream producers/consumers from the controller's hold-start-until-Done rule.
// PARAMETERS
//  W   16  operand/result width (bits)
//  CW  8   job cycle-counter width (bits); counter saturates
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   synchronous, active-low reset
//  in_valid    in   1   upstream operand valid
//  in_ready    out  1   frontend can accept an operand
//  in_data     in   W   operand to reverse
//  op_data     out  W   operand to datapath; stable whenever start=1
//  start       out  1   start request to controller
//  Done        in   1   controller done flag
//  result      in   W   reversed value from datapath; valid while Done=1
//  out_valid   out  1   result register holds an unread result
//  out_ready   in   1   downstream accepts result
//  out_data    out  W   captured result
//  out_cycles  out  CW  cycles from start rise to first Done, saturating
//  busy        out  1   state != S_IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//  - state=S_IDLE, start=0, out_valid=0.
//  - op_data, out_data, out_cycles and cyc are all cleared to 0.
//  - rst_n is shared with the controller, so both blocks restart together.
//  - Reset mid-job discards the job and any unread result.
//  in_ready = (state==S_IDLE). Combinational; does not depend on in_valid.
//  S_IDLE:
//  - On in_valid&&in_ready: op_data<=in_data, start<=1, cyc<=0, go to S_RUN.
//  - start rises 1 cycle after the accept edge.
//  - Done=1 in S_IDLE (spurious) is ignored.
//  S_RUN:
//  - cyc increments each cycle while Done=0, saturating at 2^CW-1; frozen while Done=1.
//  - cap = Done && (!out_valid || out_ready).
//  - On cap: out_data<=result, out_cycles<=cyc, out_valid<=1, start<=0, go to S_REL.
//  - Done with the output full: stay in S_RUN, start held at 1, so the controller holds its DONE state.
//  S_REL:
//  - start=0. Wait for Done==0, then go to S_IDLE.
//  - Minimum one cycle in S_REL; no new accept until back in S_IDLE.
//  Output register:
//  - out_valid&&out_ready clears out_valid unless cap occurs in the same cycle.
//  - A simultaneous drain and capture loads the new result with out_valid staying 1.
//  - out_data and out_cycles are held while out_valid=1 && !out_ready.
//  op_data changes only on accept; start never glitches (registered).
// TESTING
//  1. Accept 1234 at t; model Done at t+6 with result=4321.
//     -> start=1 from t+1; op_data=1234; out_valid=1, out_data=4321, out_cycles=5 at t+7; start=0 at t+7.
//  2. out_ready=0, two jobs (12 then 340).
//     -> Second Done holds start=1 and in_ready=0.
//     -> Pulse out_ready: 21 drains, 43 is captured in the same cycle, out_valid stays 1.
//  3. in_valid=1 with in_data=99 while busy=1.
//     -> in_ready=0; op_data unchanged; 99 accepted only after return to S_IDLE.
//  4. CW=8, Done delayed 300 cycles -> out_cycles=255.
//  5. rst_n=0 for one cycle during S_RUN.
//     -> Next cycle: start=0, out_valid=0, busy=0, in_ready=1.
//  6. Done pulse while in S_IDLE with in_valid=0 -> no state change, out_valid stays 0.

Source files
------------

// File: rtl/reverse_job_frontend.sv
// rtl/reverse_job_frontend.sv - job sequencer between valid/ready streams and the digit-reverse controller
// Holds start until Done, captures the result with its cycle count, and releases the controller.
module reverse_job_frontend #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic [W-1:0]  op_data,
    output logic          start,
    input  logic          Done,
    input  logic [W-1:0]  result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_cycles,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_REL
    } state_t;

    state_t        state_q, state_d;
    logic          start_q, start_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  op_data_q, op_data_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [CW-1:0] out_cycles_q, out_cycles_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          cap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            op_data_q    <= '0;
            out_data_q   <= '0;
            out_cycles_q <= '0;
            cyc_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            out_valid_q  <= out_valid_d;
            op_data_q    <= op_data_d;
            out_data_q   <= out_data_d;
            out_cycles_q <= out_cycles_d;
            cyc_q        <= cyc_d;
        end
    end

    // A capture may coincide with a drain; the capture wins so out_valid stays high.
    assign cap = (state_q == S_RUN) && Done && (!out_valid_q || out_ready);

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        out_valid_d  = out_valid_q;
        op_data_d    = op_data_q;
        out_data_d   = out_data_q;
        out_cycles_d = out_cycles_q;
        cyc_d        = cyc_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_data_d = in_data;
                    start_d   = 1'b1;
                    cyc_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (cap) begin
                    out_data_d   = result;
                    out_cycles_d = cyc_q;
                    out_valid_d  = 1'b1;
                    start_d      = 1'b0;
                    state_d      = S_REL;
                end else if (!Done && (cyc_q != {CW{1'b1}})) begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_REL: begin
                if (!Done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign start      = start_q;
    assign op_data    = op_data_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_cycles = out_cycles_q;

endmodule

// File: tb/tb_reverse_job_frontend.sv
// tb/tb_reverse_job_frontend.sv - directed self-checking bench for reverse_job_frontend
module tb_reverse_job_frontend;

    localparam int W  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [W-1:0]  op_data;
    logic          start;
    logic          Done;
    logic [W-1:0]  result;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_cycles;
    logic          busy;

    int passed = 0;
    int total  = 0;

    reverse_job_frontend #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .op_data    (op_data),
        .start      (start),
        .Done       (Done),
        .result     (result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cycles (out_cycles),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; Done = 1'b0;
        result = '0; out_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        total++; if ({start, out_valid, busy, in_ready} !== 4'b0001)
            $display("FAIL reset_ctrl got %b want 0001", {start, out_valid, busy, in_ready});
        else passed++;
        total++; if ({op_data, out_data, out_cycles} !== '0)
            $display("FAIL reset_data got %h/%h/%h want 0", op_data, out_data, out_cycles);
        else passed++;
    endtask

    task automatic test_basic;
        in_valid = 1'b1; in_data = 16'd1234;
        tick();
        in_valid = 1'b0;
        total++; if (start !== 1'b1 || op_data !== 16'd1234)
            $display("FAIL basic_start got start=%b op=%0d want 1/1234", start, op_data);
        else passed++;
        tick(5);
        Done = 1'b1; result = 16'd4321;
        total++; if (out_valid !== 1'b0 || start !== 1'b1)
            $display("FAIL basic_pre got ov=%b start=%b want 0/1", out_valid, start);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 16'd4321 || out_cycles !== 8'd5 || start !== 1'b0)
            $display("FAIL basic_cap got ov=%b d=%0d c=%0d s=%b want 1/4321/5/0",
                     out_valid, out_data, out_cycles, start);
        else passed++;
        total++; if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL basic_rel got busy=%b rdy=%b want 1/0", busy, in_ready);
        else passed++;
        Done = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL basic_idle got rdy=%b ov=%b want 1/1", in_ready, out_valid);
        else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0)
            $display("FAIL basic_drain got ov=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_hold;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'd12;
        tick();
        in_valid = 1'b0; Done = 1'b1; result = 16'd21;
        tick();
        Done = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 16'd340;
        tick();
        in_valid = 1'b0;
        tick();
        Done = 1'b1; result = 16'd43;
        tick(2);
        total++; if (start !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'd21 || out_cycles !== 8'd0)
            $display("FAIL hold_full got s=%b rdy=%b d=%0d c=%0d want 1/0/21/0",
                     start, in_ready, out_data, out_cycles);
        else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'd43 || out_cycles !== 8'd1 || start !== 1'b0)
            $display("FAIL hold_swap got ov=%b d=%0d c=%0d s=%b want 1/43/1/0",
                     out_valid, out_data, out_cycles, start);
        else passed++;
        Done = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL hold_end got ov=%b busy=%b want 0/0", out_valid, busy);
        else passed++;
    endtask

    task automatic test_busy;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'd500;
        tick();
        in_data = 16'd99;
        total++; if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL busy_rdy got rdy=%b busy=%b want 0/1", in_ready, busy);
        else passed++;
        tick(2);
        total++; if (op_data !== 16'd500)
            $display("FAIL busy_op got %0d want 500", op_data);
        else passed++;
        Done = 1'b1; result = 16'd5;
        tick();
        total++; if (in_ready !== 1'b0 || out_data !== 16'd5)
            $display("FAIL busy_rel got rdy=%b d=%0d want 0/5", in_ready, out_data);
        else passed++;
        Done = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1)
            $display("FAIL busy_back got rdy=%b want 1", in_ready);
        else passed++;
        tick();
        in_valid = 1'b0;
        total++; if (op_data !== 16'd99 || start !== 1'b1)
            $display("FAIL busy_acc got op=%0d s=%b want 99/1", op_data, start);
        else passed++;
        Done = 1'b1; result = 16'd99;
        tick();
        Done = 1'b0;
        tick(2);
        out_ready = 1'b0;
    endtask

    task automatic test_sat;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'd7;
        tick();
        in_valid = 1'b0;
        tick(300);
        Done = 1'b1; result = 16'd7;
        tick();
        total++; if (out_cycles !== 8'd255 || out_valid !== 1'b1)
            $display("FAIL sat_cycles got c=%0d ov=%b want 255/1", out_cycles, out_valid);
        else passed++;
        Done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1; in_data = 16'd3;
        tick();
        in_valid = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if ({start, out_valid, busy, in_ready} !== 4'b0001)
            $display("FAIL mid_reset got %b want 0001", {start, out_valid, busy, in_ready});
        else passed++;
    endtask

    task automatic test_spurious;
        in_valid = 1'b0; Done = 1'b1; result = 16'hBEEF;
        tick(2);
        Done = 1'b0;
        total++; if ({start, out_valid, busy, in_ready} !== 4'b0001 || out_data !== 16'd0)
            $display("FAIL spurious got %b d=%h want 0001/0", {start, out_valid, busy, in_ready}, out_data);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_busy();
        test_sat();
        test_reset_mid();
        test_spurious();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
